// File: rtl/uart_block_ctrl_pkg.sv
// Shared definitions for the UART block sequencer around the ChaCha20 core.
// State encoding and default block geometry.
package uart_block_ctrl_pkg;

    localparam int BYTE_W      = 8;
    localparam int NBYTES_DEF  = 64;
    localparam int TIMEOUT_DEF = 2000000;

    typedef enum logic [2:0] {
        S_RX     = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_TXLOAD = 3'd3,
        S_TXCMD  = 3'd4,
        S_TXWAIT = 3'd5
    } state_e;

endpackage

// File: rtl/uart_block_ctrl_sync_edge.sv
// Two-flop synchroniser for a slow-domain level, with rise/fall pulses
// derived from the synchronised level (one clk wide each).
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    // [0],[1] are the synchroniser; [2] holds the previous synced level
    logic [2:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= 3'b000;
        end else begin
            sh_q <= {sh_q[1:0], d_i};
        end
    end

    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/uart_block_ctrl.sv
// Collects NBYTES rx bytes into a core block, runs the cipher core once,
// then streams the result block back out through the UART transmitter.
module uart_block_ctrl
    import uart_block_ctrl_pkg::*;
#(
    parameter int NBYTES  = NBYTES_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic                     tx_ready,
    output logic                     tx_cmd,
    output logic [7:0]               tx_data,
    output logic                     core_start,
    input  logic                     core_done,
    output logic [NBYTES*BYTE_W-1:0] core_din,
    input  logic [NBYTES*BYTE_W-1:0] core_dout,
    output logic                     busy,
    output logic                     frame_err,
    output logic [15:0]              frame_cnt
);

    localparam int IDX_W = $clog2(NBYTES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int BLK_W = NBYTES * BYTE_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BLK_W-1:0]   din_q;
    logic [BLK_W-1:0]   obuf_q;
    logic               tx_cmd_q;
    logic [7:0]         tx_data_q;
    logic               start_q;
    logic               ferr_q;
    logic [15:0]        fcnt_q;

    logic rx_ev;
    logic rx_fall_unused;
    logic txr_rise;
    logic txr_fall;
    logic tmo_hit;
    logic rx_drop;

    sync_edge u_rx_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (rx_done),
        .rise_o (rx_ev),
        .fall_o (rx_fall_unused)
    );

    sync_edge u_txr_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (tx_ready),
        .rise_o (txr_rise),
        .fall_o (txr_fall)
    );

    // A byte arriving in the same clk as expiry keeps the frame alive
    assign tmo_hit = (state_q == S_RX) && !rx_ev
                   && (idx_q != '0) && (cnt_q == TMO_LAST);
    assign rx_drop = rx_ev && (state_q != S_RX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RX;
            idx_q     <= '0;
            cnt_q     <= '0;
            din_q     <= '0;
            obuf_q    <= '0;
            tx_cmd_q  <= 1'b0;
            tx_data_q <= 8'h00;
            start_q   <= 1'b0;
            ferr_q    <= 1'b0;
            fcnt_q    <= 16'h0000;
        end else begin
            start_q <= 1'b0;
            ferr_q  <= tmo_hit | rx_drop;

            unique case (state_q)
                S_RX: begin
                    if (rx_ev) begin
                        din_q[BYTE_W*idx_q +: BYTE_W] <= rx_data;
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            state_q <= S_START;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (idx_q == '0) begin
                        cnt_q <= '0;
                    end else if (tmo_hit) begin
                        idx_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_START: begin
                    start_q <= 1'b1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        obuf_q  <= core_dout;
                        state_q <= S_TXLOAD;
                    end
                end
                S_TXLOAD: begin
                    tx_data_q <= obuf_q[BYTE_W*idx_q +: BYTE_W];
                    tx_cmd_q  <= 1'b1;
                    state_q   <= S_TXCMD;
                end
                S_TXCMD: begin
                    if (txr_fall) begin
                        tx_cmd_q <= 1'b0;
                        state_q  <= S_TXWAIT;
                    end
                end
                S_TXWAIT: begin
                    if (txr_rise) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            fcnt_q  <= fcnt_q + 16'd1;
                            state_q <= S_RX;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_TXLOAD;
                        end
                    end
                end
                default: begin
                    state_q <= S_RX;
                end
            endcase
        end
    end

    assign tx_cmd     = tx_cmd_q;
    assign tx_data    = tx_data_q;
    assign core_start = start_q;
    assign core_din   = din_q;
    assign busy       = (state_q != S_RX) || (idx_q != '0);
    assign frame_err  = ferr_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_uart_block_ctrl.sv
// Randomised scoreboard bench for uart_block_ctrl with behavioural
// uart_rx / uart_tx / cipher core models.
module tb_uart_block_ctrl;

    localparam int NB  = 64;
    localparam int TMO = 100;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rx_done = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            tx_ready = 1'b1;
    logic            tx_cmd;
    logic [7:0]      tx_data;
    logic            core_start;
    logic            core_done = 1'b0;
    logic [NB*8-1:0] core_din;
    logic [NB*8-1:0] core_dout = '0;
    logic            busy;
    logic            frame_err;
    logic [15:0]     frame_cnt;

    uart_block_ctrl #(.NBYTES(NB), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_cmd     (tx_cmd),
        .tx_data    (tx_data),
        .core_start (core_start),
        .core_done  (core_done),
        .core_din   (core_din),
        .core_dout  (core_dout),
        .busy       (busy),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int n_start = 0;
    int n_ferr = 0;
    int tx_in_frame = 0;
    int core_delay = 10;
    bit core_const = 1'b1;
    logic [7:0] key = 8'hA5;
    logic [7:0] expq[$];
    logic [7:0] frame[NB];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Cipher core: reversed byte order XOR key, or a constant block
    initial begin : core_model
        logic [NB*8-1:0] din;
        forever begin
            @(negedge clk);
            if (rst_n && core_start) begin
                din = core_din;
                repeat (core_delay - 1) @(negedge clk);
                for (int i = 0; i < NB; i++)
                    core_dout[8*i +: 8] = core_const ? key
                                        : (din[8*(NB-1-i) +: 8] ^ key);
                core_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    int tx_st = 0;
    int tx_cnt = 0;
    logic [7:0] tx_held = 8'h00;

    // Transmitter: accepts a pending command, stays busy, then readies
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            tx_st = 0;
            tx_ready = 1'b1;
        end else if (tx_st == 0) begin
            if (tx_cmd) begin
                tx_cnt = $urandom_range(0, 2);
                tx_st = 1;
            end
        end else if (tx_st == 1) begin
            if (tx_cnt == 0) begin
                chk("txcmd_held", tx_cmd, 1);
                tx_held = tx_data;
                tx_ready = 1'b0;
                tx_cnt = $urandom_range(6, 12);
                tx_st = 2;
            end else tx_cnt--;
        end else begin
            if (tx_cnt == 0) begin
                chk("txcmd_drop", tx_cmd, 0);
                chk("txdata_hold", tx_data, tx_held);
                tx_ready = 1'b1;
                tx_st = 0;
            end else tx_cnt--;
        end
    end

    logic prev_cmd = 1'b0;
    logic prev_start = 1'b0;
    logic prev_ferr = 1'b0;

    // Monitor: pops expected bytes as the DUT presents them
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_cmd = 1'b0;
            tx_in_frame = 0;
        end else begin
            if (tx_cmd && !prev_cmd) begin
                if (tx_in_frame == 0)
                    chk("done_to_txcmd", cyc - done_cyc, 2);
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_extra: got %0h expected none", tx_data);
                end else begin
                    chk("tx_byte", tx_data, expq.pop_front());
                end
                tx_in_frame = (tx_in_frame == NB - 1) ? 0 : tx_in_frame + 1;
            end
            prev_cmd = tx_cmd;
        end
        if (core_start) begin
            if (prev_start) chk("start_width", prev_start, 0);
            n_start++;
            start_cyc = cyc;
        end
        if (frame_err) begin
            if (prev_ferr) chk("ferr_width", prev_ferr, 0);
            n_ferr++;
        end
        prev_start = core_start;
        prev_ferr = frame_err;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        last_rx_cyc = cyc;
        repeat (3) @(negedge clk);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame();
        int s0;
        s0 = n_start;
        for (int i = 0; i < NB; i++)
            expq.push_back(core_const ? key : (frame[NB-1-i] ^ key));
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) chk("no_early_start", n_start, s0);
            send_byte(frame[i]);
            if (i == 0) chk("busy_first", busy, 1);
        end
    endtask

    task automatic wait_start(input int s0);
        int k;
        k = 0;
        while (n_start == s0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("start_count", n_start, s0 + 1);
        chk("rx_to_start", start_cyc - last_rx_cyc, 4);
    endtask

    task automatic wait_frame(input logic [15:0] tgt);
        int k;
        k = 0;
        while (frame_cnt !== tgt && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_cnt", frame_cnt, tgt);
        chk("busy_idle", busy, 0);
        chk("expq_empty", expq.size(), 0);
    endtask

    task automatic rand_frame();
        core_const = 1'b0;
        key = 8'($urandom);
        for (int i = 0; i < NB; i++) frame[i] = 8'($urandom);
    endtask

    task automatic chk_reset_outs();
        chk("rst_tx_cmd", tx_cmd, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_din", (core_din == '0), 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
    endtask

    initial begin
        int s0;
        int f0;
        int k;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Ascending bytes, constant core result
        core_const = 1'b1;
        key = 8'hA5;
        for (int i = 0; i < NB; i++) frame[i] = 8'(i);
        s0 = n_start;
        send_frame();
        wait_start(s0);
        chk("din_lo", core_din[7:0], 8'h00);
        chk("din_hi", core_din[NB*8-1 -: 8], 8'h3F);
        wait_frame(16'd1);

        // Partial frame abandoned by timeout
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        f0 = n_ferr;
        repeat (TMO + 20) @(negedge clk);
        chk("tmo_ferr", n_ferr, f0 + 1);
        chk("tmo_idle", busy, 0);
        rand_frame();
        s0 = n_start;
        send_frame();
        wait_start(s0);
        wait_frame(16'd2);

        // Byte overrun while the core is running
        rand_frame();
        core_delay = 60;
        s0 = n_start;
        send_frame();
        wait_start(s0);
        f0 = n_ferr;
        send_byte(8'($urandom));
        chk("ovr_ferr", n_ferr, f0 + 1);
        chk("ovr_busy", busy, 1);
        chk("ovr_no_start", n_start, s0 + 1);
        wait_frame(16'd3);
        core_delay = 10;

        // Reset while byte 30 is on the line
        rand_frame();
        s0 = n_start;
        send_frame();
        wait_start(s0);
        k = 0;
        while (tx_in_frame != 31 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_byte30", tx_in_frame, 31);
        k = 0;
        while (tx_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs();
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rand_frame();
        s0 = n_start;
        send_frame();
        wait_start(s0);
        wait_frame(16'd1);

        // Frame counter wrap
        force dut.fcnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.fcnt_q;
        @(negedge clk);
        chk("cnt_preset", frame_cnt, 16'hFFFF);
        rand_frame();
        s0 = n_start;
        send_frame();
        wait_start(s0);
        wait_frame(16'd0);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
